usb_fs_out_drain_arb: RTL and testbench

- Round-robin scheduler that shares the OUT protocol engine's single buffer read port among NUM_OUT_EPS endpoint consumers.
- Grants one endpoint at a time and holds the grant until that endpoint's packet is fully drained.
- Drives the per-endpoint get strobes, then demultiplexes the registered read byte into per-endpoint valid/last strobes.
- Reports packet length and the SETUP flag; sits between the OUT protocol engine and the endpoint logic.

---
 rtl/usb_fs_out_drain_arb.sv | 155 +++++++++++++++
 tb/tb_usb_fs_out_drain_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_out_drain_arb.sv
// Round-robin owner of the OUT engine read port; the grant is held until the packet drains.
// Byte valid arrives 1 cycle after get; ep_ready low pauses gets, but one in-flight byte still lands.
module usb_fs_out_drain_arb #(
  parameter int NUM_OUT_EPS = 1,
  parameter int LEN_W       = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_OUT_EPS-1:0] reset_ep,
  input  logic [NUM_OUT_EPS-1:0] out_ep_data_avail,
  input  logic [NUM_OUT_EPS-1:0] out_ep_setup,
  output logic [NUM_OUT_EPS-1:0] out_ep_data_get,
  input  logic [7:0]             out_ep_data,
  input  logic [NUM_OUT_EPS-1:0] ep_ready,
  output logic [7:0]             ep_data,
  output logic [NUM_OUT_EPS-1:0] ep_data_valid,
  output logic [NUM_OUT_EPS-1:0] ep_data_last,
  output logic                   ep_data_setup,
  output logic [LEN_W-1:0]       ep_pkt_len,
  output logic [NUM_OUT_EPS-1:0] ep_abort,
  output logic [NUM_OUT_EPS-1:0] grant
);

  localparam int IDX_W = (NUM_OUT_EPS > 1) ? $clog2(NUM_OUT_EPS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic             inflight_q, inflight_d;
  logic             setup_q, setup_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       data_q, data_d;

  logic [NUM_OUT_EPS-1:0] cand;
  logic                   pick_vld;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       gnext;
  logic                   g_avail, g_ready, g_rst;
  logic                   abort, get_now, deliver;

  assign cand = out_ep_data_avail & ep_ready & ~reset_ep;

  // First candidate at or after rr_ptr, wrapping at NUM_OUT_EPS.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = 0;
    jj       = '0;
    for (int i = 0; i < NUM_OUT_EPS; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_OUT_EPS) j = j - NUM_OUT_EPS;
      jj = IDX_W'(j);
      if (!pick_vld && cand[jj]) begin
        pick_vld = 1'b1;
        pick_idx = jj;
      end
    end
  end

  assign gnext   = (int'(gidx_q) == NUM_OUT_EPS - 1) ? '0 : gidx_q + 1'b1;
  assign g_avail = out_ep_data_avail[gidx_q];
  assign g_ready = ep_ready[gidx_q];
  assign g_rst   = reset_ep[gidx_q];

  // An endpoint reset kills both the next get and the byte already in flight.
  assign abort   = (state_q != IDLE) & g_rst & ~reset;
  assign get_now = (state_q == DRAIN) & g_avail & g_ready & ~g_rst & ~reset;
  assign deliver = (state_q == DRAIN) & inflight_q & ~g_rst & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      inflight_q <= 1'b0;
      setup_q    <= 1'b0;
      len_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      inflight_q <= inflight_d;
      setup_q    <= setup_d;
      len_q      <= len_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gidx_d     = gidx_q;
    setup_d    = setup_q;
    len_d      = len_q;
    data_d     = data_q;
    inflight_d = get_now;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = DRAIN;
          gidx_d  = pick_idx;
          setup_d = out_ep_setup[pick_idx];
          len_d   = '0;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d  = IDLE;
          rr_ptr_d = gnext;
        end else begin
          // Empty buffer ends the drain whether or not a final byte is landing now.
          if (!g_avail) state_d = DONE;
          if (deliver) begin
            data_d = out_ep_data;
            if (len_q != {LEN_W{1'b1}}) len_d = len_q + LEN_W'(1);
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        rr_ptr_d = gnext;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_ep_data_get = '0;
    ep_data_valid   = '0;
    ep_data_last    = '0;
    ep_abort        = '0;
    grant           = '0;
    if ((state_q == DRAIN) && !reset) grant[gidx_q] = 1'b1;
    if (get_now) out_ep_data_get[gidx_q] = 1'b1;
    if (deliver) begin
      ep_data_valid[gidx_q] = 1'b1;
      ep_data_last[gidx_q]  = ~g_avail;
    end
    if (abort) ep_abort[gidx_q] = 1'b1;
  end

  assign ep_data       = reset ? 8'h00 : (deliver ? out_ep_data : data_q);
  assign ep_data_setup = setup_q & ~reset;
  assign ep_pkt_len    = reset ? '0 : len_q;

endmodule

// File: tb/tb_usb_fs_out_drain_arb.sv
// Directed bench: small OUT-engine model feeds the arbiter; deliveries are logged at negedge.
module tb_usb_fs_out_drain_arb;
  localparam int N  = 4;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          eng_rst;
  logic [N-1:0]  reset_ep, out_ep_data_avail, out_ep_setup, out_ep_data_get, ep_ready;
  logic [N-1:0]  ep_data_valid, ep_data_last, ep_abort, grant;
  logic [7:0]    out_ep_data, ep_data;
  logic          ep_data_setup;
  logic [LW-1:0] ep_pkt_len;
  logic [N-1:0]  ld_vld;
  int            ld_cnt;

  usb_fs_out_drain_arb #(.NUM_OUT_EPS(N), .LEN_W(LW)) dut (
    .clk              (clk),
    .reset            (reset),
    .reset_ep         (reset_ep),
    .out_ep_data_avail(out_ep_data_avail),
    .out_ep_setup     (out_ep_setup),
    .out_ep_data_get  (out_ep_data_get),
    .out_ep_data      (out_ep_data),
    .ep_ready         (ep_ready),
    .ep_data          (ep_data),
    .ep_data_valid    (ep_data_valid),
    .ep_data_last     (ep_data_last),
    .ep_data_setup    (ep_data_setup),
    .ep_pkt_len       (ep_pkt_len),
    .ep_abort         (ep_abort),
    .grant            (grant)
  );

  always #5 clk = ~clk;

  // Engine model: byte k of a packet on endpoint e reads as 16*(e+1)+k.
  int rem [N];
  int sent[N];
  always @(posedge clk) begin
    if (eng_rst) begin
      for (int e = 0; e < N; e++) begin
        rem[e]  <= 0;
        sent[e] <= 0;
      end
      out_ep_data <= 8'h00;
    end else begin
      for (int e = 0; e < N; e++) begin
        if (out_ep_data_get[e]) begin
          out_ep_data <= 8'(16 * (e + 1) + sent[e]);
          sent[e]     <= sent[e] + 1;
          rem[e]      <= rem[e] - 1;
        end
        if (reset_ep[e]) rem[e] <= 0;
        if (ld_vld[e]) begin
          rem[e]  <= ld_cnt;
          sent[e] <= 0;
        end
      end
    end
  end

  always_comb begin
    for (int e = 0; e < N; e++) out_ep_data_avail[e] = (rem[e] > 0);
  end

  typedef struct {
    int         ep;
    logic [7:0] dat;
    logic       last;
    logic       setup;
  } ev_t;

  ev_t          evq[$];
  int           aq[$];
  int           gq[$];
  int           inv_err = 0;
  logic [N-1:0] gprev = '0;

  function automatic int idx(input logic [N-1:0] v);
    idx = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) idx = i;
  endfunction

  always @(negedge clk) begin
    ev_t ev;
    if ($countones(out_ep_data_get) > 1 || $countones(ep_data_valid) > 1 ||
        $countones(ep_data_last) > 1 || (ep_data_last & ~ep_data_valid) != '0 ||
        (out_ep_data_get & ~grant) != '0)
      inv_err <= inv_err + 1;
    if (ep_data_valid != '0) begin
      ev.ep    = idx(ep_data_valid);
      ev.dat   = ep_data;
      ev.last  = |ep_data_last;
      ev.setup = ep_data_setup;
      evq.push_back(ev);
    end
    if (ep_abort != '0) aq.push_back(idx(ep_abort));
    if (grant != '0 && gprev == '0) gq.push_back(idx(grant));
    gprev <= grant;
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [N-1:0] m, input int cnt);
    ld_vld = m;
    ld_cnt = cnt;
    tick();
    ld_vld = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string pfx);
    chk({pfx, "_grant"}, 32'(grant), 0);
    chk({pfx, "_get"},   32'(out_ep_data_get), 0);
    chk({pfx, "_valid"}, 32'(ep_data_valid), 0);
    chk({pfx, "_last"},  32'(ep_data_last), 0);
    chk({pfx, "_abort"}, 32'(ep_abort), 0);
    chk({pfx, "_data"},  32'(ep_data), 0);
    chk({pfx, "_setup"}, 32'(ep_data_setup), 0);
    chk({pfx, "_len"},   32'(ep_pkt_len), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int mark, g0, a0, n0, n1;
    logic [7:0] exp_b[8];
    reset = 1'b1; eng_rst = 1'b1; reset_ep = '0; out_ep_setup = '0;
    ep_ready = '1; ld_vld = '0; ld_cnt = 0;
    tick(3);
    eng_rst = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    chk_idle_outputs("rst");

    // Single 4-byte packet on ep0
    mark = evq.size();
    load(4'b0001, 4);
    tick(); @(negedge clk);
    chk("s1_grant", 32'(grant), 32'h1);
    chk("s1_get", 32'(out_ep_data_get), 32'h1);
    chk("s1_novalid", 32'(ep_data_valid), 0);
    tick(); @(negedge clk);
    chk("s1_valid", 32'(ep_data_valid), 32'h1);
    chk("s1_data0", 32'(ep_data), 32'h10);
    tick(3); @(negedge clk);
    chk("s1_last", 32'(ep_data_last), 32'h1);
    chk("s1_grant_held", 32'(grant), 32'h1);
    tick(); @(negedge clk);
    chk("s1_done_grant", 32'(grant), 0);
    chk("s1_len", 32'(ep_pkt_len), 4);
    tick(5);
    chk("s1_count", 32'(evq.size() - mark), 4);
    for (int i = 0; i < 4; i++) begin
      if (mark + i < evq.size()) begin
        chk($sformatf("s1_dat%0d", i), 32'(evq[mark+i].dat), 32'(8'h10 + i));
        chk($sformatf("s1_lst%0d", i), 32'(evq[mark+i].last), (i == 3) ? 1 : 0);
      end
    end

    // Round robin between ep0 and ep2, starting from rr_ptr=0
    do_reset();
    g0 = gq.size(); mark = evq.size();
    load(4'b0101, 2);
    tick(4); @(negedge clk);
    chk("s2_gap", 32'(grant), 0);
    tick(2); @(negedge clk);
    chk("s2_grant2", 32'(grant), 32'h4);
    tick(6);
    load(4'b0101, 2);
    tick(14);
    chk("s2_ngrants", 32'(gq.size() - g0), 4);
    for (int i = 0; i < 4; i++)
      if (g0 + i < gq.size()) chk($sformatf("s2_order%0d", i), 32'(gq[g0+i]), (i % 2 == 0) ? 0 : 2);
    exp_b = '{8'h10, 8'h11, 8'h30, 8'h31, 8'h10, 8'h11, 8'h30, 8'h31};
    chk("s2_count", 32'(evq.size() - mark), 8);
    for (int i = 0; i < 8; i++)
      if (mark + i < evq.size()) chk($sformatf("s2_dat%0d", i), 32'(evq[mark+i].dat), 32'(exp_b[i]));

    // ep_ready[1] pattern 1,0,0,1 across a 3-byte packet
    mark = evq.size();
    load(4'b0010, 3);
    tick(); @(negedge clk);
    chk("s3_get_c1", 32'(out_ep_data_get), 32'h2);
    tick(); ep_ready[1] = 1'b0; @(negedge clk);
    chk("s3_get_c2", 32'(out_ep_data_get), 0);
    chk("s3_inflight_valid", 32'(ep_data_valid), 32'h2);
    chk("s3_inflight_data", 32'(ep_data), 32'h20);
    tick(); @(negedge clk);
    chk("s3_get_c3", 32'(out_ep_data_get), 0);
    chk("s3_valid_c3", 32'(ep_data_valid), 0);
    tick(); ep_ready[1] = 1'b1; @(negedge clk);
    chk("s3_get_c4", 32'(out_ep_data_get), 32'h2);
    tick(); @(negedge clk);
    chk("s3_data_c5", 32'(ep_data), 32'h21);
    chk("s3_last_c5", 32'(ep_data_last), 0);
    tick(); @(negedge clk);
    chk("s3_data_c6", 32'(ep_data), 32'h22);
    chk("s3_last_c6", 32'(ep_data_last), 32'h2);
    tick(4);
    chk("s3_count", 32'(evq.size() - mark), 3);

    // SETUP flag latched at grant, then a plain OUT packet
    mark = evq.size();
    out_ep_setup = 4'b0001;
    load(4'b0001, 2);
    tick(); out_ep_setup = '0;
    tick(8);
    load(4'b0001, 2);
    tick(8);
    chk("s4_count", 32'(evq.size() - mark), 4);
    for (int i = 0; i < 4; i++)
      if (mark + i < evq.size()) chk($sformatf("s4_setup%0d", i), 32'(evq[mark+i].setup), (i < 2) ? 1 : 0);

    // reset_ep[0] after two of five bytes, ep1 waiting
    mark = evq.size(); a0 = aq.size();
    load(4'b0001, 5);
    tick(); @(negedge clk);
    chk("s5_grant0", 32'(grant), 32'h1);
    load(4'b0010, 2);
    @(negedge clk);
    chk("s5_b0", 32'(ep_data), 32'h10);
    tick(); @(negedge clk);
    chk("s5_b1", 32'(ep_data), 32'h11);
    tick(); reset_ep = 4'b0001; @(negedge clk);
    chk("s5_abort", 32'(ep_abort), 32'h1);
    chk("s5_suppress", 32'(ep_data_valid), 0);
    chk("s5_noget", 32'(out_ep_data_get), 0);
    tick(); reset_ep = '0; @(negedge clk);
    chk("s5_abort_once", 32'(ep_abort), 0);
    tick(); @(negedge clk);
    chk("s5_grant1", 32'(grant), 32'h2);
    tick(8);
    chk("s5_naborts", 32'(aq.size() - a0), 1);
    n0 = 0; n1 = 0;
    for (int i = mark; i < evq.size(); i++) begin
      if (evq[i].ep == 0) n0++;
      if (evq[i].ep == 1) n1++;
    end
    chk("s5_ep0_bytes", 32'(n0), 2);
    chk("s5_ep1_bytes", 32'(n1), 2);

    // Global reset mid-drain of ep3 clears rr_ptr back to 0
    a0 = aq.size();
    load(4'b0100, 1);
    tick(6);
    load(4'b1001, 4);
    tick(); @(negedge clk);
    chk("s6_grant3", 32'(grant), 32'h8);
    tick(); reset = 1'b1; @(negedge clk);
    chk("s6_rst_abort", 32'(ep_abort), 0);
    tick(); reset = 1'b0; @(negedge clk);
    chk_idle_outputs("s6");
    tick(); @(negedge clk);
    chk("s6_rr0", 32'(grant), 32'h1);
    tick(20);
    chk("s6_naborts", 32'(aq.size() - a0), 0);
    chk("invariants", 32'(inv_err), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
